// File: rtl/sobel_pkg.sv
// Shared types and constants for the pixel stream blocks.
package sobel_pkg;

  localparam int PIX_W        = 8;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } tx_state_t;

endpackage

// File: rtl/pixel_raster_counter.sv
// Raster position tracker: (x, y) of the pixel about to be emitted,
// plus frame/line boundary flags derived from that position.
module pixel_raster_counter
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  localparam int X_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int Y_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           first,
  output logic           last_in_line,
  output logic           last_in_frame
);

  assign first         = (x == '0) && (y == '0);
  assign last_in_line  = (x == X_W'(IMG_WIDTH - 1));
  assign last_in_frame = last_in_line && (y == Y_W'(IMG_HEIGHT - 1));

  // Step one pixel in raster order; wrap x at line end and y at frame end.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last_in_line) begin
        x <= '0;
        y <= last_in_frame ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame transmitter: unpacks 32-bit words into a one-pixel-per-cycle
// raster stream with sof/eol/eof sideband and a done pulse per frame.
module pixel_stream_tx
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              valid_out,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int NUM_WORDS = (IMG_WIDTH * IMG_HEIGHT) / PIX_PER_WORD;
  localparam int WL_W      = $clog2(NUM_WORDS + 1);
  localparam int X_W       = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int Y_W       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  tx_state_t                  state, state_next;
  logic [1:0]                 bytes_left;
  logic [WL_W-1:0]            words_left;
  logic [WORD_W-PIX_W-1:0]    buffer;
  logic                       accept, emit, clear_cnt;
  logic                       first, last_in_line, last_in_frame;
  // Coordinates are tracked for the sub-module's other users; here only the flags matter.
  logic [X_W-1:0]             x_unused;
  logic [Y_W-1:0]             y_unused;

  pixel_raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_raster (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear_cnt),
    .advance      (emit),
    .x            (x_unused),
    .y            (y_unused),
    .first        (first),
    .last_in_line (last_in_line),
    .last_in_frame(last_in_frame)
  );

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, upstream handshake and per-cycle emit decision.
  always_comb begin
    state_next = state;
    word_ready = 1'b0;
    accept     = 1'b0;
    emit       = 1'b0;
    clear_cnt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = STREAM;
          clear_cnt  = 1'b1;
        end
      end
      STREAM: begin
        word_ready = (bytes_left == 2'd0) && (words_left != '0);
        accept     = word_valid && word_ready;
        emit       = accept || (bytes_left != 2'd0);
        if (emit && last_in_frame) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word unpacking, pixel output register and sideband flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      pixel_out  <= '0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      done       <= 1'b0;
      bytes_left <= 2'd0;
      words_left <= '0;
      buffer     <= '0;
    end else begin
      done      <= (state == DONE);
      valid_out <= emit;
      sof       <= emit && first;
      eol       <= emit && last_in_line;
      eof       <= emit && last_in_frame;
      if (clear_cnt) begin
        words_left <= WL_W'(NUM_WORDS);
        bytes_left <= 2'd0;
      end
      if (accept) begin
        pixel_out  <= word_data[PIX_W-1:0];
        buffer     <= word_data[WORD_W-1:PIX_W];
        bytes_left <= 2'd3;
        words_left <= words_left - 1'b1;
      end else if (emit) begin
        pixel_out  <= buffer[PIX_W-1:0];
        buffer     <= {{PIX_W{1'b0}}, buffer[WORD_W-PIX_W-1:PIX_W]};
        bytes_left <= bytes_left - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Scoreboard bench for pixel_stream_tx: an 8x2 instance driven with directed
// and randomized frames, plus a 1x4 instance for the single-column case.
module tb_pixel_stream_tx;
  import sobel_pkg::*;

  localparam int W_A = 8;
  localparam int H_A = 2;
  localparam int N_A = W_A * H_A;
  localparam int W_B = 1;
  localparam int H_B = 4;
  localparam int N_B = W_B * H_B;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_ready, valid_out, sof, eol, eof, busy, done;
  logic [7:0]  pixel_out;

  logic        b_rst = 1'b1, b_start = 1'b0, b_word_valid = 1'b0;
  logic [31:0] b_word_data = '0;
  logic        b_word_ready, b_valid_out, b_sof, b_eol, b_eof, b_busy, b_done;
  logic [7:0]  b_pixel_out;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  int   pix_seen   = 0;
  int   done_count = 0;
  logic [7:0] last_pix = '0;
  logic have_pix = 1'b0;
  logic exp_done = 1'b0;

  always #5 clk = ~clk;

  pixel_stream_tx #(.IMG_WIDTH(W_A), .IMG_HEIGHT(H_A)) u_dut (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_ready(word_ready), .valid_out(valid_out),
    .pixel_out(pixel_out), .sof(sof), .eol(eol), .eof(eof), .busy(busy),
    .done(done)
  );

  pixel_stream_tx #(.IMG_WIDTH(W_B), .IMG_HEIGHT(H_B)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .word_valid(b_word_valid),
    .word_data(b_word_data), .word_ready(b_word_ready), .valid_out(b_valid_out),
    .pixel_out(b_pixel_out), .sof(b_sof), .eol(b_eol), .eof(b_eof), .busy(b_busy),
    .done(b_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pixel i of the frame is byte (i%4) of word (i/4); sideband from raster position.
  function automatic exp_t model(input logic [31:0] w, input int i, input int wid, input int npix);
    exp_t e;
    logic [31:0] wv;
    wv    = w >> (8 * (i % 4));
    e.pix = wv[7:0];
    e.sof = (i == 0);
    e.eol = ((i % wid) == wid - 1);
    e.eof = (i == npix - 1);
    return e;
  endfunction

  task automatic push_word(input logic [31:0] w, input int base);
    for (int b = 0; b < 4; b++) q.push_back(model(w, base + b, W_A, N_A));
  endtask

  // Monitor for the 8x2 instance: pops the scoreboard on every presented pixel.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      have_pix = 1'b0;
      exp_done = 1'b0;
    end else begin
      check("done_timing", done, exp_done);
      if (done) done_count++;
      exp_done = valid_out && eof;
      if (valid_out) begin
        if (q.size() == 0) begin
          check("unexpected_pixel", {pixel_out, sof, eol, eof}, 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pixel_and_sideband", {pixel_out, sof, eol, eof}, e);
        end
        last_pix = pixel_out;
        have_pix = 1'b1;
        pix_seen++;
      end else if (have_pix) begin
        check("bubble_hold", {pixel_out, sof, eol, eof}, {last_pix, 3'b000});
      end
    end
  end

  // mode 0: word_valid held; 1: toggled every 3 cycles; 2: random.
  task automatic run_frame(input logic [31:0] w[4], input int mode, input int start_at,
                           input int rst_at);
    int given, cyc, done0;
    logic v, mid_started;
    pix_seen = 0;
    given = 0; cyc = 0; mid_started = 1'b0;
    done0 = done_count;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    while (done_count == done0 && cyc < 300) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cyc / 3) % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      word_valid = v;
      word_data  = (given < 4) ? w[given] : 32'hDEAD_BEEF;
      if (given == 4) check("ready_after_last_word", word_ready, 1'b0);
      if (v && word_ready && given < 4) begin
        push_word(w[given], 4 * given);
        given++;
      end
      if (start_at >= 0 && pix_seen == start_at && !mid_started) begin
        start = 1'b1;
        mid_started = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (rst_at >= 0 && pix_seen == rst_at) begin
        rst = 1'b1;
        start = 1'b0;
        word_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        check("abort_valid_out", valid_out, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_word_ready", word_ready, 1'b0);
        check("abort_state_idle", u_dut.state, IDLE);
        return;
      end
      @(negedge clk); #1;
      cyc++;
    end
    word_valid = 1'b0;
    start = 1'b0;
    check("single_done_pulse", done_count - done0, 1);
    check("pixels_in_frame", pix_seen, N_A);
    check("scoreboard_empty", q.size(), 0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ramp[4];
    logic [31:0] rw[4];
    int got_b, done_b;
    exp_t eb;
    ramp[0] = 32'h0302_0100; ramp[1] = 32'h0706_0504;
    ramp[2] = 32'h0B0A_0908; ramp[3] = 32'h0F0E_0D0C;

    // Reset with start also asserted: reset must win.
    start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    check("reset_valid_out", valid_out, 1'b0);
    check("reset_outputs", {pixel_out, sof, eol, eof, busy, done, word_ready}, '0);
    check("reset_state_idle", u_dut.state, IDLE);

    // Word offered while idle must not be taken.
    word_valid = 1'b1;
    word_data  = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("idle_word_ready", word_ready, 1'b0);
      check("idle_no_pixel", valid_out, 1'b0);
    end
    word_valid = 1'b0;

    run_frame(ramp, 0, -1, -1);
    run_frame(ramp, 1, -1, -1);
    run_frame(ramp, 0, 5, -1);
    run_frame(ramp, 0, -1, 9);
    run_frame(ramp, 0, -1, -1);
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) rw[k] = $urandom;
      run_frame(rw, 2, -1, -1);
    end

    // Single-column frame on the second instance.
    @(negedge clk); #1;
    b_rst = 1'b0;
    b_start = 1'b1;
    @(negedge clk); #1;
    b_start = 1'b0;
    b_word_valid = 1'b1;
    b_word_data = 32'hDDCC_BBAA;
    got_b = 0; done_b = 0;
    for (int c = 0; c < 30 && done_b == 0; c++) begin
      @(negedge clk);
      if (b_valid_out) begin
        eb = model(32'hDDCC_BBAA, got_b, W_B, N_B);
        check("col_pixel_and_sideband", {b_pixel_out, b_sof, b_eol, b_eof}, eb);
        got_b++;
      end
      if (b_done) done_b++;
      #1;
      if (got_b > 0) check("col_ready_after_word", b_word_ready, 1'b0);
    end
    b_word_valid = 1'b0;
    check("col_pixel_count", got_b, N_B);
    check("col_done_seen", done_b, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_stream_tx.md
Name: pixel_stream_tx

Overview:
- Frame-level pixel transmitter that drives the 8-bit valid-qualified pixel stream consumed by the edge-detection datapath.
- Accepts 32-bit packed words (4 pixels/word) from a memory/DMA-side valid/ready source and emits one pixel per cycle in raster order.
- Adds start-of-frame (sof), end-of-line (eol) and end-of-frame (eof) sideband signals and frame start/done control.
- Sits between the frame fetch logic and the pixel-processing pipeline.

Parameters:
- IMG_WIDTH, 64, pixels per line; must be at least 1.
- IMG_HEIGHT, 64, lines per frame; must be at least 1.
- Constraint: IMG_WIDTH*IMG_HEIGHT must be a multiple of 4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless the state is IDLE.
- word_valid  in  1  upstream word valid.
- word_data  in  32  packed pixels; byte 0 ([7:0]) is emitted first, byte 3 last.
- word_ready  out  1  transmitter can accept a word this cycle.
- valid_out  out  1  pixel_out is valid.
- pixel_out  out  8  pixel data.
- sof  out  1  first pixel of the frame; qualified by valid_out.
- eol  out  1  last pixel of a line; qualified by valid_out.
- eof  out  1  last pixel of the frame; qualified by valid_out.
- busy  out  1  high in STREAM and DONE.
- done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset values: every output is 0. Internal state: IDLE; x, y, bytes_left and words_left are all 0.
- IDLE state:
  - word_ready = 0.
  - On start: go to STREAM, set words_left = W*H/4, clear x and y.
- STREAM state:
  - word_ready = (bytes_left == 0) && (words_left != 0). It is combinational from registered state and does not depend on word_valid.
  - Word accepted (word_valid && word_ready): next edge loads pixel_out = word_data[7:0], valid_out = 1, buffer = bytes 1..3, bytes_left = 3, words_left decrements. Latency is 1 cycle from accept to byte 0.
  - Otherwise, if bytes_left > 0: emit the next buffered byte in order, valid_out = 1, bytes_left decrements.
  - Otherwise: valid_out = 0 (bubble); pixel_out holds its last value; sof, eol and eof are 0.
  - Throughput: with word_valid held high, sustained rate is 1 pixel/cycle with no bubbles (the next word is accepted in the same cycle byte 3 is presented).
- Raster counters:
  - Each emitted pixel carries its (x, y). x increments per pixel and wraps to 0 after IMG_WIDTH-1, at which point y increments.
  - sof = (x == 0 && y == 0). eol = (x == IMG_WIDTH-1). eof = eol && (y == IMG_HEIGHT-1).
  - With IMG_WIDTH = 1, every pixel has eol = 1.
- Frame end:
  - The edge that emits the eof pixel moves the state to DONE.
  - DONE lasts exactly one cycle with done = 1, then returns to IDLE.
  - done is high in the cycle immediately after the eof pixel is presented.
  - After the final word is accepted, word_ready stays 0. Excess upstream words are not consumed.
- start while in STREAM or DONE: ignored, with no effect on counters.
- rst mid-frame: all state and outputs return to reset values on the next edge. The partial frame is abandoned; no eof or done is produced.
- start and rst in the same cycle: rst wins.
- Upstream stalls (word_valid low) only insert bubbles; x and y advance only on emitted pixels.
- Arithmetic:
  - x is $clog2(IMG_WIDTH) bits and y is $clog2(IMG_HEIGHT) bits; both are at least 1 bit.
  - words_left is wide enough to hold W*H/4.
  - bytes_left is 2 bits.

Decomposition:
- Shared package sobel_pkg:
  - Constants PIX_W = 8, WORD_W = 32, PIX_PER_WORD = 4.
  - State enum tx_state_t {IDLE, STREAM, DONE}.
- One sub-module: pixel_raster_counter.
  - Parameters: IMG_WIDTH, IMG_HEIGHT.
  - Inputs: clk, rst, clear, advance.
  - Outputs: x, y, first, last_in_line, last_in_frame.
  - Reused later by the receive side of the pipeline.

Test Plan (IMG_WIDTH = 8, IMG_HEIGHT = 2 unless noted):
- Reset, then start, then 4 back-to-back words (0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C) with word_valid held high:
  - valid_out high for 16 consecutive cycles with pixel_out 0x00..0x0F.
  - sof on 0x00; eol on 0x07 and 0x0F; eof on 0x0F.
  - done exactly one cycle later; word_ready never high after the 4th accept.
- Same frame with word_valid toggled 1/0 every 3 cycles:
  - Identical pixel sequence and sideband signals; bubbles have valid_out = 0 with pixel_out held.
  - Total of 16 valid pixels.
- Pulse start mid-frame at pixel 5: no restart; sequence 0x00..0x0F unchanged; a single done pulse.
- Assert rst at pixel 9:
  - Next cycle: valid_out, busy and word_ready are 0 and the state is IDLE.
  - A new start followed by 4 words streams a full clean frame, with sof on the first pixel.
- Word offered before start (word_valid = 1 in IDLE): word_ready stays 0 and no pixels are emitted until start.
- IMG_WIDTH = 1, IMG_HEIGHT = 4, one word 0xDDCCBBAA:
  - Pixels 0xAA, 0xBB, 0xCC, 0xDD, each with eol = 1.
  - sof only on 0xAA; eof only on 0xDD.
